stopwatch_ctrl: RTL and testbench

- Timekeeping stage directly downstream of the clock divider.
- Consumes the divider's slow toggle outputs (clk_milisec, clk_500ms) as data signals, not as clocks. Everything runs on the single system clock `clk`.
- Keeps an mm:ss.fff stopwatch driven by start/stop/clear commands. Outputs BCD digits plus a colon-blink flag for the display driver.

---
 rtl/stopwatch_ctrl_pkg.sv | 25 ++
 rtl/stopwatch_ctrl_toggle_edge_sync.sv | 49 ++++
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the mm:ss.fff stopwatch and its display driver.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int BCD_W                 = 4;
  localparam int FRAC_W                = 10;
  localparam int DEFAULT_TICKS_PER_SEC = 1000;
  localparam int DEFAULT_MAX_MIN       = 59;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t        min_tens;
    bcd_digit_t        min_ones;
    bcd_digit_t        sec_tens;
    bcd_digit_t        sec_ones;
    logic [FRAC_W-1:0] frac;
  } sw_time_t;

endpackage

// File: rtl/stopwatch_ctrl_toggle_edge_sync.sv
// Synchronizes slow divider toggles into the clk domain; the edge channel also
// yields a registered one-cycle pulse on each rising transition.
module toggle_edge_sync #(
  parameter int STAGES  = 2,
  parameter int LEVEL_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_edge,
  input  logic [LEVEL_W-1:0] din_level,
  output logic               rise,
  output logic [LEVEL_W-1:0] synced_level
);

  if (STAGES < 2) begin : g_bad_stages
    $error("toggle_edge_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0]              edge_q, edge_d;
  logic [STAGES-1:0][LEVEL_W-1:0] level_q, level_d;
  logic                           hist_q, hist_d;
  logic                           rise_q, rise_d;

  // New samples enter at index 0; the oldest (fully synchronized) sits at STAGES-1.
  always_comb begin
    edge_d  = {edge_q[STAGES-2:0], din_edge};
    level_d = {level_q[STAGES-2:0], din_level};
    hist_d  = edge_q[STAGES-1];
    rise_d  = edge_q[STAGES-1] & ~hist_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q  <= '0;
      level_q <= '0;
      hist_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      level_q <= level_d;
      hist_q  <= hist_d;
      rise_q  <= rise_d;
    end
  end

  assign rise         = rise_q;
  assign synced_level = level_q[STAGES-1];

endmodule

// File: rtl/stopwatch_ctrl.sv
// mm:ss.fff stopwatch with start/stop/clear control, fed by the divider's
// millisecond and half-second toggles sampled as data on the system clock.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int MAX_MIN       = DEFAULT_MAX_MIN,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_milisec,
  input  logic              clk_500ms,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  output logic [FRAC_W-1:0] frac,
  output logic [BCD_W-1:0]  sec_ones,
  output logic [BCD_W-1:0]  sec_tens,
  output logic [BCD_W-1:0]  min_ones,
  output logic [BCD_W-1:0]  min_tens,
  output logic              running,
  output logic              colon,
  output logic              wrap
);

  if (TICKS_PER_SEC > 1024 || TICKS_PER_SEC < 2) begin : g_bad_tps
    $error("stopwatch_ctrl: TICKS_PER_SEC must be in 2..1024 (frac is 10 bits)");
  end
  if (MAX_MIN < 0 || MAX_MIN > 59) begin : g_bad_max_min
    $error("stopwatch_ctrl: MAX_MIN must be in 0..59");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("stopwatch_ctrl: SYNC_STAGES must be at least 2");
  end

  localparam logic [FRAC_W-1:0] FRAC_LAST = FRAC_W'(TICKS_PER_SEC - 1);
  localparam bcd_digit_t        MAXM_TENS = BCD_W'(MAX_MIN / 10);
  localparam bcd_digit_t        MAXM_ONES = BCD_W'(MAX_MIN % 10);

  logic tick;
  logic half_sec_lvl;

  toggle_edge_sync #(
    .STAGES  (SYNC_STAGES),
    .LEVEL_W (1)
  ) u_sync (
    .clk          (clk),
    .rst          (rst),
    .din_edge     (clk_milisec),
    .din_level    (clk_500ms),
    .rise         (tick),
    .synced_level (half_sec_lvl)
  );

  sw_state_e state_q, state_d;
  sw_time_t  time_q, time_d;
  logic      running_q, running_d;
  logic      colon_q, colon_d;
  logic      wrap_q, wrap_d;
  logic      count_en;

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    wrap_d   = 1'b0;
    // A tick counts against the pre-edge state; clear always discards it.
    count_en = (state_q == ST_RUN) && tick && !clear;

    if (count_en) begin
      if (time_q.frac != FRAC_LAST) begin
        time_d.frac = time_q.frac + 1'b1;
      end else begin
        time_d.frac = '0;
        if (time_q.sec_ones != 4'd9) begin
          time_d.sec_ones = time_q.sec_ones + 4'd1;
        end else begin
          time_d.sec_ones = '0;
          if (time_q.sec_tens != 4'd5) begin
            time_d.sec_tens = time_q.sec_tens + 4'd1;
          end else begin
            time_d.sec_tens = '0;
            if (time_q.min_tens == MAXM_TENS && time_q.min_ones == MAXM_ONES) begin
              time_d.min_tens = '0;
              time_d.min_ones = '0;
              wrap_d          = 1'b1;
            end else if (time_q.min_ones != 4'd9) begin
              time_d.min_ones = time_q.min_ones + 4'd1;
            end else begin
              time_d.min_ones = '0;
              time_d.min_tens = time_q.min_tens + 4'd1;
            end
          end
        end
      end
    end

    if (clear) begin
      state_d = ST_IDLE;
      time_d  = '0;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start) begin
      if (state_q != ST_RUN) state_d = ST_RUN;
    end

    running_d = (state_d == ST_RUN);
    case (state_d)
      ST_RUN:   colon_d = half_sec_lvl;
      ST_PAUSE: colon_d = 1'b1;
      default:  colon_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      running_q <= 1'b0;
      colon_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= running_d;
      colon_q   <= colon_d;
      wrap_q    <= wrap_d;
    end
  end

  assign frac     = time_q.frac;
  assign sec_ones = time_q.sec_ones;
  assign sec_tens = time_q.sec_tens;
  assign min_ones = time_q.min_ones;
  assign min_tens = time_q.min_tens;
  assign running  = running_q;
  assign colon    = colon_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (default and small wrap-friendly
// parameters) share stimulus and are compared against a tick-total model.
module tb_stopwatch_ctrl;

  localparam int SYNC    = 2;
  localparam int TPS0    = 1000;
  localparam int MM0     = 59;
  localparam int TPS1    = 8;
  localparam int MM1     = 2;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, clk_milisec, clk_500ms, start, stop, clear;
  logic [9:0] frac_o [2];
  logic [3:0] so_o [2];
  logic [3:0] st_o [2];
  logic [3:0] mo_o [2];
  logic [3:0] mt_o [2];
  logic       running_o [2];
  logic       colon_o [2];
  logic       wrap_o [2];

  always #5 clk = ~clk;

  stopwatch_ctrl dut0 (
    .clk(clk), .rst(rst), .clk_milisec(clk_milisec), .clk_500ms(clk_500ms),
    .start(start), .stop(stop), .clear(clear),
    .frac(frac_o[0]), .sec_ones(so_o[0]), .sec_tens(st_o[0]),
    .min_ones(mo_o[0]), .min_tens(mt_o[0]),
    .running(running_o[0]), .colon(colon_o[0]), .wrap(wrap_o[0])
  );

  stopwatch_ctrl #(.TICKS_PER_SEC(TPS1), .MAX_MIN(MM1), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst(rst), .clk_milisec(clk_milisec), .clk_500ms(clk_500ms),
    .start(start), .stop(stop), .clear(clear),
    .frac(frac_o[1]), .sec_ones(so_o[1]), .sec_tens(st_o[1]),
    .min_ones(mo_o[1]), .min_tens(mt_o[1]),
    .running(running_o[1]), .colon(colon_o[1]), .wrap(wrap_o[1])
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int m_state  = S_IDLE;
  int m_tot   [2] = '{0, 0};
  int m_wraps [2] = '{0, 0};
  int seen_wraps [2] = '{0, 0};
  int long_wraps [2] = '{0, 0};
  logic wrap_prev [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wrap_o[i] === 1'b1) begin
        seen_wraps[i] <= seen_wraps[i] + 1;
        if (wrap_prev[i] === 1'b1) long_wraps[i] <= long_wraps[i] + 1;
      end
      wrap_prev[i] <= wrap_o[i];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tps_of(input int i);
    return (i == 0) ? TPS0 : TPS1;
  endfunction

  function automatic int limit_of(input int i);
    return (i == 0) ? (MM0 + 1) * 60 * TPS0 : (MM1 + 1) * 60 * TPS1;
  endfunction

  task automatic m_tick();
    if (m_state == S_RUN) begin
      for (int i = 0; i < 2; i++) begin
        m_tot[i]++;
        if (m_tot[i] == limit_of(i)) begin
          m_tot[i] = 0;
          m_wraps[i]++;
        end
      end
    end
  endtask

  task automatic m_cmd(input bit s, input bit p, input bit c);
    if (c) begin
      m_state = S_IDLE;
      m_tot   = '{0, 0};
    end else if (p) begin
      if (m_state == S_RUN) m_state = S_PAUSE;
    end else if (s) begin
      m_state = S_RUN;
    end
  endtask

  task automatic check_display(input string tag, input bit w0, input bit w1);
    for (int i = 0; i < 2; i++) begin
      int tp, f, s, sec, mn, ec;
      bit ew;
      tp  = tps_of(i);
      f   = m_tot[i] % tp;
      s   = m_tot[i] / tp;
      sec = s % 60;
      mn  = s / 60;
      ew  = (i == 0) ? w0 : w1;
      ec  = (m_state == S_RUN) ? int'(clk_500ms) : ((m_state == S_PAUSE) ? 1 : 0);
      check_val($sformatf("%s.u%0d.frac", tag, i), 32'(frac_o[i]), f);
      check_val($sformatf("%s.u%0d.sec_ones", tag, i), 32'(so_o[i]), sec % 10);
      check_val($sformatf("%s.u%0d.sec_tens", tag, i), 32'(st_o[i]), sec / 10);
      check_val($sformatf("%s.u%0d.min_ones", tag, i), 32'(mo_o[i]), mn % 10);
      check_val($sformatf("%s.u%0d.min_tens", tag, i), 32'(mt_o[i]), mn / 10);
      check_val($sformatf("%s.u%0d.running", tag, i), 32'(running_o[i]), (m_state == S_RUN) ? 1 : 0);
      check_val($sformatf("%s.u%0d.colon", tag, i), 32'(colon_o[i]), ec);
      check_val($sformatf("%s.u%0d.wrap", tag, i), 32'(wrap_o[i]), 32'(ew));
    end
  endtask

  task automatic check_wrap_hist(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("%s.u%0d.wrap_count", tag, i), seen_wraps[i], m_wraps[i]);
      check_val($sformatf("%s.u%0d.wrap_width", tag, i), long_wraps[i], 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (SYNC + 4) step();
  endtask

  task automatic give_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      clk_milisec = 1'b1;
      repeat ($urandom_range(1, 2)) step();
      clk_milisec = 1'b0;
      repeat ($urandom_range(1, 2)) step();
      m_tick();
    end
    settle();
  endtask

  task automatic cmd(input bit s, input bit p, input bit c);
    start = s;
    stop  = p;
    clear = c;
    step();
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    m_cmd(s, p, c);
  endtask

  // Commands are presented in the very cycle the internal tick pulse is high.
  task automatic cmd_with_tick(input bit s, input bit p, input bit c);
    clk_milisec = 1'b1;
    repeat (SYNC + 1) step();
    start = s;
    stop  = p;
    clear = c;
    step();
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    clk_milisec = 1'b0;
    if (!c) m_tick();
    m_cmd(s, p, c);
    settle();
  endtask

  // One tick with exact latency: unchanged after SYNC+1 edges, updated after SYNC+2.
  task automatic tick_timed(input string tag);
    int w_before [2];
    w_before = m_wraps;
    clk_milisec = 1'b1;
    repeat (SYNC + 1) step();
    @(negedge clk);
    check_display({tag, ".early"}, 1'b0, 1'b0);
    step();
    m_tick();
    @(negedge clk);
    check_display({tag, ".edge"}, m_wraps[0] != w_before[0], m_wraps[1] != w_before[1]);
    clk_milisec = 1'b0;
    step();
    @(negedge clk);
    check_display({tag, ".after"}, 1'b0, 1'b0);
    settle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timed out");
  end

  initial begin
    rst = 1'b1; clk_milisec = 1'b0; clk_500ms = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_display("reset", 1'b0, 1'b0);

    give_ticks(10);
    check_display("idle_ticks", 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_display("idle_stop", 1'b0, 1'b0);

    cmd(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_val("start.running", 32'(running_o[0]), 1);
    tick_timed("lat");
    give_ticks(1233);
    check_display("count1234", 1'b0, 1'b0);
    clk_500ms = 1'b0;
    settle();
    check_display("colon_run_lo", 1'b0, 1'b0);
    clk_500ms = 1'b1;
    settle();
    check_display("colon_run_hi", 1'b0, 1'b0);

    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0);
    give_ticks(5500);
    check_display("at5500", 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0);
    give_ticks(300);
    check_display("paused", 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0);
    give_ticks(600);
    check_display("resumed", 1'b0, 1'b0);
    check_wrap_hist("resume");

    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0);
    give_ticks(10);
    cmd_with_tick(1'b1, 1'b1, 1'b1);
    check_display("all_cmds_tick", 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0);
    give_ticks(5);
    cmd_with_tick(1'b1, 1'b1, 1'b0);
    check_display("stop_start_tick", 1'b0, 1'b0);

    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0);
    give_ticks(limit_of(1) - 1);
    check_display("pre_wrap", 1'b0, 1'b0);
    tick_timed("wrap");
    check_wrap_hist("wrap");

    for (int it = 0; it < 40; it++) begin
      int r;
      clk_500ms = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 4);
      case (r)
        0: cmd(1'b1, 1'b0, 1'b0);
        1: cmd(1'b0, 1'b1, 1'b0);
        2: cmd(1'b0, 1'b0, ($urandom_range(0, 3) == 0));
        3: cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: cmd_with_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
      endcase
      give_ticks($urandom_range(0, 20));
      check_display($sformatf("rand%0d", it), 1'b0, 1'b0);
    end
    check_wrap_hist("rand");

    clk_500ms = 1'b1;
    cmd(1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0);
    give_ticks(150 * TPS1 + 2);
    check_display("pre_rst", 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_state = S_IDLE;
    m_tot   = '{0, 0};
    @(negedge clk);
    check_display("mid_rst", 1'b0, 1'b0);
    settle();
    check_wrap_hist("mid_rst");
    cmd(1'b1, 1'b0, 1'b0);
    tick_timed("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
